// File: rtl/decode_pipe_reg_if.sv
// Decode->execute boundary bundle: decoded fields in, registered fields out.
interface decode_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int OP_W    = 4
);
  logic [OP_W-1:0]    alu_opcode;
  logic               reg_flag;
  logic [RADDR_W-1:0] rd;
  logic [DATA_W-1:0]  rs1;
  logic [DATA_W-1:0]  rs2;
  logic [DATA_W-1:0]  immidiate_data;
  logic               reg_wr_en;

  logic [OP_W-1:0]    alu_opout;
  logic [RADDR_W-1:0] rd_out;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op2;
  logic               reg_wr_en_out;
  logic               flag_out;
  logic [DATA_W-1:0]  data;

  // Decoder side drives the fields and sees what execute will receive.
  modport master (
    output alu_opcode, reg_flag, rd, rs1, rs2, immidiate_data, reg_wr_en,
    input  alu_opout, rd_out, op1, op2, reg_wr_en_out, flag_out, data
  );

  modport slave (
    input  alu_opcode, reg_flag, rd, rs1, rs2, immidiate_data, reg_wr_en,
    output alu_opout, rd_out, op1, op2, reg_wr_en_out, flag_out, data
  );
endinterface

// File: rtl/decode_pipe_reg.sv
// Decode->execute pipeline register; selects ALU operand 2 before capture.
module decode_pipe_reg (
  input  logic             clk,
  input  logic             reset,
  decode_pipe_reg_if.slave bus
);

  // Reset clears every field so a flushed slot never writes back.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alu_opout     <= '0;
      bus.rd_out        <= '0;
      bus.op1           <= '0;
      bus.op2           <= '0;
      bus.reg_wr_en_out <= 1'b0;
      bus.flag_out      <= 1'b0;
      bus.data          <= '0;
    end else begin
      bus.alu_opout     <= bus.alu_opcode;
      bus.rd_out        <= bus.rd;
      bus.op1           <= bus.rs1;
      bus.op2           <= bus.reg_flag ? bus.rs2 : bus.immidiate_data;
      bus.reg_wr_en_out <= bus.reg_wr_en;
      bus.flag_out      <= bus.reg_flag;
      bus.data          <= bus.rs2;
    end
  end

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Directed bench for decode_pipe_reg: reset, R/I-type capture, latency, mid-stream reset.
module tb_decode_pipe_reg;

  typedef struct {
    logic [3:0]  alu_opcode;
    logic        reg_flag;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        reg_wr_en;
  } vec_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  decode_pipe_reg_if #(.DATA_W(32), .RADDR_W(5), .OP_W(4)) bus ();

  decode_pipe_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    bus.alu_opcode     = v.alu_opcode;
    bus.reg_flag       = v.reg_flag;
    bus.rd             = v.rd;
    bus.rs1            = v.rs1;
    bus.rs2            = v.rs2;
    bus.immidiate_data = v.imm;
    bus.reg_wr_en      = v.reg_wr_en;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".alu_opout"}, 32'(bus.alu_opout), 32'h0);
    checkOutput({tag, ".rd_out"}, 32'(bus.rd_out), 32'h0);
    checkOutput({tag, ".op1"}, bus.op1, 32'h0);
    checkOutput({tag, ".op2"}, bus.op2, 32'h0);
    checkOutput({tag, ".wr_en"}, 32'(bus.reg_wr_en_out), 32'h0);
    checkOutput({tag, ".flag"}, 32'(bus.flag_out), 32'h0);
    checkOutput({tag, ".data"}, bus.data, 32'h0);
  endtask

  task automatic checkVec(input string tag, input vec_t v, input logic [31:0] exp_op2);
    checkOutput({tag, ".alu_opout"}, 32'(bus.alu_opout), 32'(v.alu_opcode));
    checkOutput({tag, ".rd_out"}, 32'(bus.rd_out), 32'(v.rd));
    checkOutput({tag, ".op1"}, bus.op1, v.rs1);
    checkOutput({tag, ".op2"}, bus.op2, exp_op2);
    checkOutput({tag, ".wr_en"}, 32'(bus.reg_wr_en_out), 32'(v.reg_wr_en));
    checkOutput({tag, ".flag"}, 32'(bus.flag_out), 32'(v.reg_flag));
    checkOutput({tag, ".data"}, bus.data, v.rs2);
  endtask

  task automatic stepAndCheck(input string tag, input vec_t v, input logic [31:0] exp_op2);
    @(negedge clk);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkVec(tag, v, exp_op2);
  endtask

  vec_t r_vec, i_vec, ones_vec, junk_vec;

  initial begin
    r_vec    = '{4'b1010, 1'b1, 5'b10001, 32'h1, 32'h10, 32'h1111_1111, 1'b1};
    i_vec    = '{4'b0101, 1'b0, 5'b01010, 32'h11, 32'h100, 32'h2222_2222, 1'b1};
    ones_vec = '{4'b1111, 1'b0, 5'b11111, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFE, 1'b0};
    junk_vec = '{4'b0011, 1'b1, 5'b00111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 1'b1};

    // Reset held for two edges with nonzero inputs.
    reset = 1'b1;
    applyStimulus(junk_vec);
    @(posedge clk);
    #1;
    checkZero("rst1");
    @(posedge clk);
    #1;
    checkZero("rst2");

    @(negedge clk);
    reset = 1'b0;
    stepAndCheck("rtype", r_vec, 32'h10);
    stepAndCheck("itype", i_vec, 32'h2222_2222);
    stepAndCheck("ones", ones_vec, 32'hFFFF_FFFE);
    stepAndCheck("junk", junk_vec, 32'hCAFE_F00D);

    // Mid-cycle input change must not reach the outputs before the edge.
    stepAndCheck("lat_pre", i_vec, 32'h2222_2222);
    applyStimulus(r_vec);
    #3;
    checkVec("lat_hold", i_vec, 32'h2222_2222);
    @(posedge clk);
    #1;
    checkVec("lat_new", r_vec, 32'h10);

    stepAndCheck("b2b_r", r_vec, 32'h10);
    stepAndCheck("b2b_i", i_vec, 32'h2222_2222);
    stepAndCheck("b2b_r2", r_vec, 32'h10);

    // Reset asserted during the I-type vector, then released.
    @(negedge clk);
    applyStimulus(i_vec);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkZero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkVec("post_rst", i_vec, 32'h2222_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
